// File: rtl/threshold_trigger.sv
// rtl/threshold_trigger.sv - leading-edge discriminator with peak/length capture, hold-off and miss counting
// An event is opened and closed against a threshold latched at trigger time; the record is held until accepted.
module threshold_trigger #(
  parameter int N_P     = 12,
  parameter int W_LEN   = 8,
  parameter int HOLDOFF = 16,
  parameter int W_MISS  = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic [N_P-1:0]   sample_i,
  input  logic             sample_valid_i,
  input  logic [N_P-1:0]   threshold_i,
  output logic             trig_o,
  output logic             busy_o,
  output logic             event_valid_o,
  input  logic             event_ready_i,
  output logic [N_P-1:0]   event_peak_o,
  output logic [W_LEN-1:0] event_len_o,
  output logic [W_MISS-1:0] miss_count_o
);

  localparam int W_HO = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [W_HO-1:0] HO_LOAD = W_HO'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

  typedef enum logic [1:0] {
    ARMED   = 2'd0,
    ABOVE   = 2'd1,
    REPORT  = 2'd2,
    HOLDOFF_ST = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [N_P-1:0]    thr_lat_q, thr_lat_d;
  logic [N_P-1:0]    acc_peak_q, acc_peak_d;
  logic [W_LEN-1:0]  acc_len_q, acc_len_d;
  logic [N_P-1:0]    peak_q, peak_d;
  logic [W_LEN-1:0]  len_q, len_d;
  logic              trig_q, trig_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic [W_MISS-1:0] miss_q, miss_d;
  logic [W_HO-1:0]   ho_cnt_q, ho_cnt_d;
  logic              prev_hi_q, prev_hi_d;

  logic above_live;
  logic above_lat;

  assign above_live = sample_valid_i && ($signed(sample_i) > $signed(threshold_i));
  assign above_lat  = sample_valid_i && ($signed(sample_i) > $signed(thr_lat_q));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= ARMED;
      thr_lat_q  <= '0;
      acc_peak_q <= '0;
      acc_len_q  <= '0;
      peak_q     <= '0;
      len_q      <= '0;
      trig_q     <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      miss_q     <= '0;
      ho_cnt_q   <= '0;
      prev_hi_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_lat_q  <= thr_lat_d;
      acc_peak_q <= acc_peak_d;
      acc_len_q  <= acc_len_d;
      peak_q     <= peak_d;
      len_q      <= len_d;
      trig_q     <= trig_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      miss_q     <= miss_d;
      ho_cnt_q   <= ho_cnt_d;
      prev_hi_q  <= prev_hi_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    thr_lat_d  = thr_lat_q;
    acc_peak_d = acc_peak_q;
    acc_len_d  = acc_len_q;
    peak_d     = peak_q;
    len_d      = len_q;
    trig_d     = 1'b0;
    valid_d    = valid_q;
    miss_d     = miss_q;
    ho_cnt_d   = ho_cnt_q;
    prev_hi_d  = prev_hi_q;

    // Dead-time miss detection: only rising crossings against the live threshold count.
    if ((state_q == REPORT || state_q == HOLDOFF_ST) && sample_valid_i) begin
      prev_hi_d = above_live;
      if (enable_i && above_live && !prev_hi_q && (miss_q != '1)) begin
        miss_d = miss_q + 1'b1;
      end
    end

    case (state_q)
      ARMED: begin
        if (enable_i && above_live) begin
          thr_lat_d  = threshold_i;
          acc_peak_d = sample_i;
          acc_len_d  = {{(W_LEN-1){1'b0}}, 1'b1};
          trig_d     = 1'b1;
          state_d    = ABOVE;
        end
      end
      ABOVE: begin
        if (sample_valid_i) begin
          if (above_lat) begin
            if (acc_len_q != '1) acc_len_d = acc_len_q + 1'b1;
            if ($signed(sample_i) > $signed(acc_peak_q)) acc_peak_d = sample_i;
          end else begin
            peak_d    = acc_peak_q;
            len_d     = acc_len_q;
            valid_d   = 1'b1;
            prev_hi_d = 1'b0;
            state_d   = REPORT;
          end
        end
      end
      REPORT: begin
        if (valid_q && event_ready_i) begin
          valid_d   = 1'b0;
          prev_hi_d = 1'b0;
          if (HOLDOFF == 0) begin
            state_d = ARMED;
          end else begin
            ho_cnt_d = HO_LOAD;
            state_d  = HOLDOFF_ST;
          end
        end
      end
      default: begin
        if (ho_cnt_q == '0) begin
          state_d = ARMED;
        end else begin
          ho_cnt_d = ho_cnt_q - 1'b1;
        end
      end
    endcase

    busy_d = (state_d != ARMED);
  end

  assign trig_o        = trig_q;
  assign busy_o        = busy_q;
  assign event_valid_o = valid_q;
  assign event_peak_o  = peak_q;
  assign event_len_o   = len_q;
  assign miss_count_o  = miss_q;

endmodule
